// File: rtl/video_pkg.sv
// Shared raster timing defaults, phase/mode encodings and timing helpers
// for the video timing generator and its pattern source.
package video_pkg;

  localparam logic [5:0] DEF_VSW  = 6'd1;
  localparam logic [5:0] DEF_VBP  = 6'd1;
  localparam logic [5:0] DEF_VACT = 6'd4;
  localparam logic [5:0] DEF_VFP  = 6'd1;
  localparam logic [5:0] DEF_HSW  = 6'd1;
  localparam logic [5:0] DEF_HBP  = 6'd2;
  localparam logic [5:0] DEF_HACT = 6'd10;
  localparam logic [5:0] DEF_HFP  = 6'd2;

  // Phase of one raster axis; identical encoding for horizontal and vertical.
  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    MODE_COORD   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_GREY    = 2'd3
  } mode_t;

  // Four 6-bit fields sum to at most 252, so 8 bits always suffice.
  function automatic logic [7:0] calc_htot(input logic [5:0] sw, input logic [5:0] bp,
                                           input logic [5:0] act, input logic [5:0] fp);
    return {2'b00, sw} + {2'b00, bp} + {2'b00, act} + {2'b00, fp};
  endfunction

  function automatic logic [7:0] calc_vtot(input logic [5:0] sw, input logic [5:0] bp,
                                           input logic [5:0] act, input logic [5:0] fp);
    return {2'b00, sw} + {2'b00, bp} + {2'b00, act} + {2'b00, fp};
  endfunction

  // Map a counter value onto sync / back porch / active / front porch.
  function automatic phase_t decode_phase(input logic [7:0] cnt, input logic [5:0] sw,
                                          input logic [5:0] bp, input logic [5:0] act);
    logic [7:0] end_sync;
    logic [7:0] end_bp;
    logic [7:0] end_act;
    end_sync = {2'b00, sw};
    end_bp   = end_sync + {2'b00, bp};
    end_act  = end_bp + {2'b00, act};
    if (cnt < end_sync)     return PH_SYNC;
    else if (cnt < end_bp)  return PH_BP;
    else if (cnt < end_act) return PH_ACT;
    else                    return PH_FP;
  endfunction

endpackage

// File: rtl/pattern_gen.sv
// Combinational test pattern source: pixel coordinate, latched mode and
// frame counter in, 3x10-bit RGB out. Blanking is applied by the caller.
module pattern_gen
  import video_pkg::*;
#(
  parameter logic [5:0] HACT = DEF_HACT
) (
  input  logic [5:0] x,
  input  logic [5:0] y,
  input  mode_t      mode,
  input  logic [9:0] frame_cnt,
  output logic [9:0] r,
  output logic [9:0] g,
  output logic [9:0] b
);

  logic [2:0] bar;
  logic [2:0] bar_code;

  // Eight equal-width bars across the active line; only x < HACT is ever shown.
  assign bar      = 3'(({x, 3'b000}) / {3'b000, HACT});
  assign bar_code = 3'd7 - bar;

  // Select the pattern for the current pixel.
  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    case (mode)
      MODE_COORD: begin
        r = {4'b0000, x};
        g = {4'b0000, y};
        b = frame_cnt;
      end
      MODE_BARS: begin
        r = {10{bar_code[2]}};
        g = {10{bar_code[1]}};
        b = {10{bar_code[0]}};
      end
      MODE_CHECKER: begin
        if (x[0] ^ y[0]) begin
          r = 10'h3FF;
          g = 10'h3FF;
          b = 10'h3FF;
        end
      end
      MODE_GREY: begin
        r = 10'h200;
        g = 10'h200;
        b = 10'h200;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, phase decode and the registered
// sync / data-enable / RGB output stage.
//
// phase   | meaning (same for h on h_cnt and v on v_cnt)
// PH_SYNC | sync pulse active
// PH_BP   | back porch, blanked
// PH_ACT  | active region, de asserted when both axes are here
// PH_FP   | front porch, blanked
module video_timing_gen
  import video_pkg::*;
#(
  parameter logic [5:0] VSW  = DEF_VSW,
  parameter logic [5:0] VBP  = DEF_VBP,
  parameter logic [5:0] VACT = DEF_VACT,
  parameter logic [5:0] VFP  = DEF_VFP,
  parameter logic [5:0] HSW  = DEF_HSW,
  parameter logic [5:0] HBP  = DEF_HBP,
  parameter logic [5:0] HACT = DEF_HACT,
  parameter logic [5:0] HFP  = DEF_HFP
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  output logic       o_vsync,
  output logic       o_hsync,
  output logic       o_de,
  output logic [9:0] o_r_data,
  output logic [9:0] o_g_data,
  output logic [9:0] o_b_data,
  output logic       o_frame_done
);

  localparam logic [7:0] HTOT        = calc_htot(HSW, HBP, HACT, HFP);
  localparam logic [7:0] VTOT        = calc_vtot(VSW, VBP, VACT, VFP);
  localparam logic [7:0] H_ACT_START = {2'b00, HSW} + {2'b00, HBP};
  localparam logic [7:0] V_ACT_START = {2'b00, VSW} + {2'b00, VBP};

  logic [7:0] h_cnt;
  logic [7:0] v_cnt;
  logic [9:0] frame_cnt;
  mode_t      mode_q;

  phase_t     h_state;
  phase_t     v_state;
  logic       de_next;
  logic       h_last;
  logic       v_last;
  logic [5:0] pix_x;
  logic [5:0] pix_y;
  logic [9:0] pat_r;
  logic [9:0] pat_g;
  logic [9:0] pat_b;

  // Decode the current counter position into phases and pixel coordinates.
  always_comb begin
    h_state = decode_phase(h_cnt, HSW, HBP, HACT);
    v_state = decode_phase(v_cnt, VSW, VBP, VACT);
    de_next = (h_state == PH_ACT) && (v_state == PH_ACT);
    h_last  = (h_cnt == HTOT - 8'd1);
    v_last  = (v_cnt == VTOT - 8'd1);
    pix_x   = 6'(h_cnt - H_ACT_START);
    pix_y   = 6'(v_cnt - V_ACT_START);
  end

  pattern_gen #(
    .HACT(HACT)
  ) u_pattern_gen (
    .x        (pix_x),
    .y        (pix_y),
    .mode     (mode_q),
    .frame_cnt(frame_cnt),
    .r        (pat_r),
    .g        (pat_g),
    .b        (pat_b)
  );

  // Advance the raster and register all outputs one clock behind the counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      frame_cnt    <= '0;
      mode_q       <= MODE_COORD;
      o_vsync      <= 1'b0;
      o_hsync      <= 1'b0;
      o_de         <= 1'b0;
      o_r_data     <= '0;
      o_g_data     <= '0;
      o_b_data     <= '0;
      o_frame_done <= 1'b0;
    end else if (!i_en) begin
      // Disable restarts the raster but keeps frame_cnt and the latched mode.
      h_cnt        <= '0;
      v_cnt        <= '0;
      o_vsync      <= 1'b0;
      o_hsync      <= 1'b0;
      o_de         <= 1'b0;
      o_r_data     <= '0;
      o_g_data     <= '0;
      o_b_data     <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_vsync      <= (v_state == PH_SYNC);
      o_hsync      <= (h_state == PH_SYNC);
      o_de         <= de_next;
      o_r_data     <= de_next ? pat_r : 10'd0;
      o_g_data     <= de_next ? pat_g : 10'd0;
      o_b_data     <= de_next ? pat_b : 10'd0;
      o_frame_done <= h_last && v_last;

      // Pattern changes only land on a frame boundary.
      if (h_cnt == 8'd0 && v_cnt == 8'd0) begin
        mode_q <= mode_t'(i_mode);
      end

      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 10'd1;
        end else begin
          v_cnt <= v_cnt + 8'd1;
        end
      end else begin
        h_cnt <= h_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default raster (HTOT=15, VTOT=7) plus
// a second instance with minimal porches and a single active line.
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_en = 1'b0;
  logic       en_b = 1'b0;
  logic [1:0] i_mode = 2'd0;

  logic       vs, hs, de, fd;
  logic [9:0] r, g, b;
  logic       vs_b, hs_b, de_b, fd_b;
  logic [9:0] r_b, g_b, b_b;

  int checks = 0;
  int failures = 0;

  logic       cap_vs[105];
  logic       cap_hs[105];
  logic       cap_de[105];
  logic       cap_fd[105];
  logic [9:0] cap_r[105];
  logic [9:0] cap_g[105];
  logic [9:0] cap_b[105];

  // Hand-computed bar index x*8/10 for x = 0..9.
  int bar_tab[10] = '{0, 0, 1, 2, 3, 4, 4, 5, 6, 7};

  always #5 clk = ~clk;

  video_timing_gen dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_en        (i_en),
    .i_mode      (i_mode),
    .o_vsync     (vs),
    .o_hsync     (hs),
    .o_de        (de),
    .o_r_data    (r),
    .o_g_data    (g),
    .o_b_data    (b),
    .o_frame_done(fd)
  );

  video_timing_gen #(
    .HSW (6'd1),
    .HBP (6'd1),
    .HFP (6'd1),
    .VACT(6'd1)
  ) dut_b (
    .clk         (clk),
    .rstn        (rstn),
    .i_en        (en_b),
    .i_mode      (i_mode),
    .o_vsync     (vs_b),
    .o_hsync     (hs_b),
    .o_de        (de_b),
    .o_r_data    (r_b),
    .o_g_data    (g_b),
    .o_b_data    (b_b),
    .o_frame_done(fd_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture one 105-clock frame; optionally change i_mode after output sw_k.
  task automatic capture(input int sw_k, input logic [1:0] sw_mode);
    for (int k = 0; k < 105; k++) begin
      step();
      cap_vs[k] = vs;
      cap_hs[k] = hs;
      cap_de[k] = de;
      cap_fd[k] = fd;
      cap_r[k]  = r;
      cap_g[k]  = g;
      cap_b[k]  = b;
      if (k == sw_k) i_mode = sw_mode;
    end
  endtask

  function automatic logic [29:0] exp_pix(input int m, input int x, input int y, input int fc);
    logic [9:0] er, eg, eb;
    int code;
    er = '0;
    eg = '0;
    eb = '0;
    case (m)
      0: begin
        er = 10'(x);
        eg = 10'(y);
        eb = 10'(fc);
      end
      1: begin
        code = 7 - bar_tab[x];
        er = code[2] ? 10'h3FF : 10'h000;
        eg = code[1] ? 10'h3FF : 10'h000;
        eb = code[0] ? 10'h3FF : 10'h000;
      end
      2: begin
        if ((x % 2) != (y % 2)) begin
          er = 10'h3FF;
          eg = 10'h3FF;
          eb = 10'h3FF;
        end
      end
      default: begin
        er = 10'h200;
        eg = 10'h200;
        eb = 10'h200;
      end
    endcase
    return {er, eg, eb};
  endfunction

  // Default raster: h 0 sync, 1-2 bp, 3-12 act, 13-14 fp; v 0 sync, 1 bp, 2-5 act, 6 fp.
  task automatic check_frame(input string tag, input int m, input int fc);
    int n_vs = 0, n_hs = 0, n_de = 0, n_fd = 0;
    int bad_sync = 0, bad_de = 0, bad_pix = 0;
    int h, v;
    logic exp_de;
    logic [29:0] exp;
    for (int k = 0; k < 105; k++) begin
      h = k % 15;
      v = k / 15;
      exp_de = (h >= 3 && h <= 12 && v >= 2 && v <= 5);
      n_vs += int'(cap_vs[k]);
      n_hs += int'(cap_hs[k]);
      n_de += int'(cap_de[k]);
      n_fd += int'(cap_fd[k]);
      if (cap_vs[k] !== (v == 0)) bad_sync++;
      if (cap_hs[k] !== (h == 0)) bad_sync++;
      if (cap_de[k] !== exp_de) bad_de++;
      exp = exp_de ? exp_pix(m, h - 3, v - 2, fc) : 30'd0;
      if ({cap_r[k], cap_g[k], cap_b[k]} !== exp) bad_pix++;
    end
    check_val({tag, "_vsync_clks"}, n_vs, 15);
    check_val({tag, "_hsync_pulses"}, n_hs, 7);
    check_val({tag, "_de_clks"}, n_de, 40);
    check_val({tag, "_done_cnt"}, n_fd, 1);
    check_val({tag, "_done_last"}, cap_fd[104], 1);
    check_val({tag, "_sync_pos_errs"}, bad_sync, 0);
    check_val({tag, "_de_pos_errs"}, bad_de, 0);
    check_val({tag, "_pixel_errs"}, bad_pix, 0);
  endtask

  initial begin
    int nz;
    int n_de_b, first_b, last_b, fd_at, n_vs_b, n_hs_b;

    // Reset dominates even with enable high.
    rstn = 1'b0;
    i_en = 1'b1;
    i_mode = 2'd0;
    step();
    step();
    check_val("reset_outputs", {vs, hs, de, fd, r, g, b}, 0);
    rstn = 1'b1;

    // Frames 0..2, coordinate pattern; request bars for frame 3.
    capture(-1, 2'd0);
    check_val("f0_first_de_k33", cap_de[33], 1);
    check_val("f0_de_before_k33", cap_de[32], 0);
    check_val("f0_r_x9", cap_r[42], 9);
    check_val("f0_g_y0", cap_g[35], 0);
    check_val("f0_b", cap_b[33], 0);
    check_frame("f0", 0, 0);
    capture(-1, 2'd0);
    check_val("f1_b", cap_b[33], 1);
    check_val("f1_g_y3", cap_g[5 * 15 + 4], 3);
    check_frame("f1", 0, 1);
    capture(50, 2'd1);
    check_frame("f2", 0, 2);

    // Frame 3 bars; switch to grey mid-frame.
    capture(50, 2'd3);
    check_val("f3_bar_x0_white", {cap_r[33], cap_g[33], cap_b[33]}, 30'h3FFFFFFF);
    check_val("f3_bar_x9_black", {cap_r[42], cap_g[42], cap_b[42]}, 0);
    check_val("f3_bar_x2", {cap_r[35], cap_g[35], cap_b[35]}, {10'h3FF, 10'h3FF, 10'h000});
    check_frame("f3", 1, 3);

    // Frame 4 grey; frame 5 checker; frame 6 back to coordinates.
    capture(50, 2'd2);
    check_val("f4_grey_pix", cap_r[40], 10'h200);
    check_frame("f4", 3, 4);
    capture(50, 2'd0);
    check_frame("f5", 2, 5);

    // Reset at h=7, v=3 of frame 6.
    for (int k = 0; k < 52; k++) step();
    check_val("f6_pre_rst_de", de, 1);
    check_val("f6_pre_rst_rgb", {r, g, b}, {10'd3, 10'd1, 10'd6});
    rstn = 1'b0;
    step();
    check_val("midrst_outputs", {vs, hs, de, fd, r, g, b}, 0);
    rstn = 1'b1;
    capture(-1, 2'd0);
    check_val("postrst_vsync0", cap_vs[0], 1);
    check_val("postrst_hsync0", cap_hs[0], 1);
    check_frame("postrst", 0, 0);

    // Enable low for 20 clocks mid-frame; frame_cnt is 1 here.
    for (int k = 0; k < 40; k++) step();
    i_en = 1'b0;
    nz = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if ({vs, hs, de, fd, r, g, b} != 0) nz++;
    end
    check_val("en_low_nonzero_clks", nz, 0);
    i_en = 1'b1;
    capture(-1, 2'd0);
    check_val("reen_vsync0", cap_vs[0], 1);
    check_val("reen_hsync0", cap_hs[0], 1);
    check_frame("reen", 0, 1);

    // Minimal porches: HTOT=13, VTOT=4, de at k=28..37, done at k=51.
    en_b = 1'b1;
    n_de_b = 0;
    first_b = -1;
    last_b = -1;
    fd_at = -1;
    n_vs_b = 0;
    n_hs_b = 0;
    for (int k = 0; k < 52; k++) begin
      step();
      if (de_b) begin
        n_de_b++;
        if (first_b < 0) first_b = k;
        last_b = k;
      end
      if (fd_b) fd_at = k;
      n_vs_b += int'(vs_b);
      n_hs_b += int'(hs_b);
    end
    check_val("b_de_clks", n_de_b, 10);
    check_val("b_de_first", first_b, 28);
    check_val("b_de_last", last_b, 37);
    check_val("b_done_k", fd_at, 51);
    check_val("b_vsync_clks", n_vs_b, 13);
    check_val("b_hsync_pulses", n_hs_b, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
